// File: rtl/snoop_resp_aggr_pkg.sv
// Shared definitions for the ACE snoop-response aggregator.
//   - CRRESP bit positions and width
//   - FSM state type and state encodings
//   - clog2_min1: index/counter width helper that never returns 0
package snoop_resp_aggr_pkg;

  // CRRESP bit positions
  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;
  localparam int unsigned CrRespW        = 5;

  // Round FSM
  typedef logic [2:0] state_t;
  localparam state_t StIdle    = 3'd0;
  localparam state_t StCollect = 3'd1;
  localparam state_t StSelect  = 3'd2;
  localparam state_t StXfer    = 3'd3;
  localparam state_t StDone    = 3'd4;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snoop_resp_aggr_if.sv
// Snoop-path bundle between the snooped masters / initiator and the aggregator.
//   slave  : aggregator view (receives snoop start, CR and CD; drives readies, output
//            stream, merged response and status)
//   master : environment view (the opposite directions)
// Signals:
//   snp_start/snp_mask        round start and snooped-master mask
//   cr_valid/cr_resp/cr_ready per-master CR channel, master i at cr_resp[5i+4:5i]
//   cd_valid/cd_data/cd_last/cd_ready  per-master CD channel
//   out_valid/out_data/out_last/out_ready  selected line to the initiator
//   resp_valid/resp/no_data   merged CRRESP pulse
//   src_idx/busy/err          status
interface snoop_resp_aggr_if #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned NUM_MASTERS = 8,
  parameter int unsigned IDX_W       = 3
);
  import snoop_resp_aggr_pkg::*;

  logic                            snp_start;
  logic [NUM_MASTERS-1:0]          snp_mask;
  logic [NUM_MASTERS-1:0]          cr_valid;
  logic [NUM_MASTERS*CrRespW-1:0]  cr_resp;
  logic [NUM_MASTERS-1:0]          cr_ready;
  logic [NUM_MASTERS-1:0]          cd_valid;
  logic [NUM_MASTERS*DATA_W-1:0]   cd_data;
  logic [NUM_MASTERS-1:0]          cd_last;
  logic [NUM_MASTERS-1:0]          cd_ready;
  logic                            out_valid;
  logic [DATA_W-1:0]               out_data;
  logic                            out_last;
  logic                            out_ready;
  logic                            resp_valid;
  logic [CrRespW-1:0]              resp;
  logic                            no_data;
  logic [IDX_W-1:0]                src_idx;
  logic                            busy;
  logic                            err;

  modport slave (
    input  snp_start, snp_mask, cr_valid, cr_resp, cd_valid, cd_data, cd_last, out_ready,
    output cr_ready, cd_ready, out_valid, out_data, out_last, resp_valid, resp, no_data,
           src_idx, busy, err
  );

  modport master (
    output snp_start, snp_mask, cr_valid, cr_resp, cd_valid, cd_data, cd_last, out_ready,
    input  cr_ready, cd_ready, out_valid, out_data, out_last, resp_valid, resp, no_data,
           src_idx, busy, err
  );

endinterface

// File: rtl/snoop_resp_aggr_prio_enc.sv
// prio_enc: find-first-set priority encoder; the lowest set request bit wins.
//   req_i   : request vector
//   idx_o   : index of the lowest set bit (0 when none)
//   found_o : any bit set
module prio_enc
  import snoop_resp_aggr_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = clog2_min1(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = |req_i;
    // Scan downwards so the last hit written is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/snoop_resp_aggr.sv
// snoop_resp_aggr: ACE snoop-response aggregator.
// Collects CR responses from the snooped masters, picks one data source (dirty data first,
// then lowest-index clean data), streams its CD beats through a registered output stage and
// drains the CD data of every other responder. One merged CRRESP pulse per round.
// Ports:
//   ACLK     clock
//   ARESETn  synchronous active-low reset
//   bus      snoop_resp_aggr_if.slave bundle (CR/CD per master, output stream, merged resp)
module snoop_resp_aggr
  import snoop_resp_aggr_pkg::*;
#(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned NUM_MASTERS = 8,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned IDX_W       = clog2_min1(NUM_MASTERS)
) (
  input logic              ACLK,
  input logic              ARESETn,
  snoop_resp_aggr_if.slave bus
);

  localparam int unsigned    CntW     = clog2_min1(BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  // State
  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] pending_q, pending_d;
  logic [NUM_MASTERS-1:0] has_data_q, has_data_d;
  logic [NUM_MASTERS-1:0] dirty_q, dirty_d;
  logic                   or_shared_q, or_shared_d;
  logic                   or_unique_q, or_unique_d;
  logic                   or_error_q, or_error_d;
  logic [IDX_W-1:0]       src_q, src_d;
  logic                   src_found_q, src_found_d;
  logic                   src_dirty_q, src_dirty_d;
  logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   err_q, err_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [CrRespW-1:0]     resp_q, resp_d;
  logic                   no_data_q, no_data_d;

  // Combinational helpers
  logic [NUM_MASTERS-1:0] cr_ready;
  logic [NUM_MASTERS-1:0] cd_ready;
  logic [CrRespW-1:0]     cr_r;
  logic                   out_free;
  logic                   src_is_last;
  logic [IDX_W-1:0]       dirty_idx, data_idx;
  logic                   dirty_found, data_found;

  prio_enc #(
    .N    (NUM_MASTERS),
    .IdxW (IDX_W)
  ) u_dirty_enc (
    .req_i   (dirty_q),
    .idx_o   (dirty_idx),
    .found_o (dirty_found)
  );

  prio_enc #(
    .N    (NUM_MASTERS),
    .IdxW (IDX_W)
  ) u_data_enc (
    .req_i   (has_data_q),
    .idx_o   (data_idx),
    .found_o (data_found)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    has_data_d   = has_data_q;
    dirty_d      = dirty_q;
    or_shared_d  = or_shared_q;
    or_unique_d  = or_unique_q;
    or_error_d   = or_error_q;
    src_d        = src_q;
    src_found_d  = src_found_q;
    src_dirty_d  = src_dirty_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_d       = resp_q;
    no_data_d    = no_data_q;
    cr_ready     = '0;
    cd_ready     = '0;
    cr_r         = '0;
    out_free     = !out_valid_q || bus.out_ready;
    src_is_last  = (beat_cnt_q == LastBeat);

    case (state_q)
      StIdle: begin
        if (bus.snp_start) begin
          pending_d   = bus.snp_mask;
          has_data_d  = '0;
          dirty_d     = '0;
          or_shared_d = 1'b0;
          or_unique_d = 1'b0;
          or_error_d  = 1'b0;
          src_d       = '0;
          src_found_d = 1'b0;
          src_dirty_d = 1'b0;
          beat_cnt_d  = '0;
          err_d       = 1'b0;
          state_d     = (bus.snp_mask == '0) ? StDone : StCollect;
        end
      end

      StCollect: begin
        cr_ready = pending_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (bus.cr_valid[i] && pending_q[i]) begin
            cr_r          = bus.cr_resp[CrRespW*i +: CrRespW];
            pending_d[i]  = 1'b0;
            has_data_d[i] = cr_r[CrDataTransfer];
            dirty_d[i]    = cr_r[CrDataTransfer] & cr_r[CrPassDirty];
            or_shared_d   = or_shared_d | cr_r[CrIsShared];
            or_unique_d   = or_unique_d | cr_r[CrWasUnique];
            or_error_d    = or_error_d | cr_r[CrError];
          end
        end
        if (pending_d == '0) begin
          state_d = StSelect;
        end
      end

      StSelect: begin
        if (dirty_found) begin
          src_d       = dirty_idx;
          src_found_d = 1'b1;
          src_dirty_d = 1'b1;
          state_d     = StXfer;
        end else if (data_found) begin
          src_d       = data_idx;
          src_found_d = 1'b1;
          src_dirty_d = 1'b0;
          state_d     = StXfer;
        end else begin
          state_d = StDone;
        end
      end

      StXfer: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (has_data_q[i]) begin
            if (IDX_W'(i) == src_q) begin
              cd_ready[i] = out_free;
              if (bus.cd_valid[i] && out_free) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.cd_data[DATA_W*i +: DATA_W];
                out_last_d  = src_is_last;
                // The beat counter, not cd_last, decides where the line ends.
                if (bus.cd_last[i] != src_is_last) begin
                  err_d = 1'b1;
                end
                if (src_is_last) begin
                  has_data_d[i] = 1'b0;
                  beat_cnt_d    = '0;
                end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
                end
              end
            end else begin
              // Non-selected responder: accept and discard until its last beat.
              cd_ready[i] = 1'b1;
              if (bus.cd_valid[i] && bus.cd_last[i]) begin
                has_data_d[i] = 1'b0;
              end
            end
          end
        end
        // Src bit already cleared and the final beat leaves the output register this cycle.
        if (has_data_q == '0 && !out_valid_d) begin
          state_d = StDone;
        end
      end

      StDone: begin
        resp_valid_d           = 1'b1;
        resp_d[CrDataTransfer] = src_found_q;
        resp_d[CrError]        = or_error_q | err_q;
        resp_d[CrPassDirty]    = src_dirty_q;
        resp_d[CrIsShared]     = or_shared_q;
        resp_d[CrWasUnique]    = or_unique_q;
        no_data_d              = !src_found_q;
        state_d                = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      has_data_q   <= '0;
      dirty_q      <= '0;
      or_shared_q  <= 1'b0;
      or_unique_q  <= 1'b0;
      or_error_q   <= 1'b0;
      src_q        <= '0;
      src_found_q  <= 1'b0;
      src_dirty_q  <= 1'b0;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      no_data_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      has_data_q   <= has_data_d;
      dirty_q      <= dirty_d;
      or_shared_q  <= or_shared_d;
      or_unique_q  <= or_unique_d;
      or_error_q   <= or_error_d;
      src_q        <= src_d;
      src_found_q  <= src_found_d;
      src_dirty_q  <= src_dirty_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      no_data_q    <= no_data_d;
    end
  end

  assign bus.cr_ready   = cr_ready;
  assign bus.cd_ready   = cd_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp       = resp_q;
  assign bus.no_data    = no_data_q;
  assign bus.src_idx    = (state_q == StXfer) ? src_q : '0;
  assign bus.busy       = (state_q != StIdle);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_snoop_resp_aggr.sv
// Scoreboard bench for snoop_resp_aggr: the round driver computes the expected output line
// and merged response from the selection rules and queues them; a negedge monitor pops and
// compares whenever the DUT presents a beat or a response.
module tb_snoop_resp_aggr;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned N           = 8;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned RoundBudget = 1000;

  typedef logic [DATA_W:0] wide_t;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  snoop_resp_aggr_if #(.DATA_W(DATA_W), .NUM_MASTERS(N), .IDX_W(IDX_W)) bus ();

  snoop_resp_aggr #(
    .DATA_W      (DATA_W),
    .NUM_MASTERS (N),
    .BEATS       (BEATS),
    .IDX_W       (IDX_W)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int resp_seen = 0;
  int resp_cyc  = 0;
  int exp_src   = 0;

  wide_t      exp_beat_q[$];
  logic [5:0] exp_resp_q[$];

  logic [4:0]        r_resp [N];
  logic [DATA_W-1:0] r_data [N][BEATS];

  task automatic check(input string name, input wide_t act, input wide_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=event-missing-or-extra required=as-modelled", name);
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Monitor
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_beat_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          check("out_beat", wide_t'({bus.out_last, bus.out_data}), exp_beat_q.pop_front());
          check("src_idx", wide_t'(bus.src_idx), wide_t'(exp_src));
        end
      end
      if (bus.resp_valid) begin
        resp_cyc = cyc;
        resp_seen++;
        if (exp_resp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          check("resp", wide_t'({bus.no_data, bus.resp}), wide_t'(exp_resp_q.pop_front()));
        end
      end
    end
  end

  task automatic drive_idle();
    bus.snp_start = 1'b0;
    bus.snp_mask  = '0;
    bus.cr_valid  = '0;
    bus.cr_resp   = '0;
    bus.cd_valid  = '0;
    bus.cd_data   = '0;
    bus.cd_last   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, wide_t'({bus.cr_ready, bus.cd_ready, bus.out_valid, bus.out_last,
                         bus.resp_valid, bus.resp, bus.no_data, bus.src_idx, bus.busy,
                         bus.err}), '0);
    check({name, "_data"}, wide_t'(bus.out_data), '0);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    drive_idle();
    repeat (2) @(posedge ACLK);
    #1;
    check_outputs_zero("reset_outputs");
    ARESETn = 1'b1;
  endtask

  task automatic fill_data();
    for (int i = 0; i < N; i++) begin
      r_resp[i] = 5'($urandom);
      for (int k = 0; k < BEATS; k++) begin
        r_data[i][k] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic run_round(input string tag, input logic [N-1:0] mask, input bit early,
                           input bit abort, input bit toggle_rdy);
    int         src;
    bit         found;
    logic [4:0] er;
    bit         exp_err;
    bit         cr_done [N];
    int         cd_k [N];
    logic [N-1:0] hs_cr, hs_cd;
    int         seen0, start_cyc;
    bit         fin, aborted;

    // Reference model: dirty data wins, then lowest clean data, else no data.
    found = 1'b0;
    src   = 0;
    for (int i = 0; i < N; i++)
      if (!found && mask[i] && r_resp[i][0] && r_resp[i][2]) begin found = 1'b1; src = i; end
    for (int i = 0; i < N; i++)
      if (!found && mask[i] && r_resp[i][0]) begin found = 1'b1; src = i; end
    exp_err = early && found;
    er      = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        er[1] = er[1] | r_resp[i][1];
        er[3] = er[3] | r_resp[i][3];
        er[4] = er[4] | r_resp[i][4];
      end
    end
    er[0] = found;
    er[2] = found && r_resp[src][2];
    er[1] = er[1] | exp_err;
    if (found)
      for (int k = 0; k < BEATS; k++)
        exp_beat_q.push_back({(k == BEATS - 1) ? 1'b1 : 1'b0, r_data[src][k]});
    exp_resp_q.push_back({!found, er});
    exp_src = src;

    for (int i = 0; i < N; i++) begin cr_done[i] = 1'b0; cd_k[i] = 0; end
    bus.snp_mask  = mask;
    bus.snp_start = 1'b1;
    start_cyc     = cyc;
    seen0         = resp_seen;
    fin           = 1'b0;
    aborted       = 1'b0;

    for (int c = 0; c < RoundBudget && !fin; c++) begin
      @(negedge ACLK);
      hs_cr = bus.cr_valid & bus.cr_ready;
      hs_cd = bus.cd_valid & bus.cd_ready;
      @(posedge ACLK);
      #1;
      if (c == 0) begin
        bus.snp_start = 1'b0;
        check({tag, "_busy"}, wide_t'(bus.busy), wide_t'(1));
        check({tag, "_err_clr"}, wide_t'(bus.err), '0);
      end
      for (int i = 0; i < N; i++) begin
        if (hs_cr[i]) cr_done[i] = 1'b1;
        if (hs_cd[i]) cd_k[i]++;
      end
      if (resp_seen != seen0) begin
        fin = 1'b1;
      end else if (abort && found && cd_k[src] >= 2) begin
        ARESETn = 1'b0;
        drive_idle();
        @(posedge ACLK);
        #1;
        check_outputs_zero({tag, "_abort"});
        exp_beat_q.delete();
        exp_resp_q.delete();
        ARESETn = 1'b1;
        repeat (6) @(posedge ACLK);
        #1;
        check({tag, "_no_resp"}, wide_t'(resp_seen), wide_t'(seen0));
        fin     = 1'b1;
        aborted = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (mask[i] && !cr_done[i]) begin
            if (!bus.cr_valid[i]) bus.cr_valid[i] = ($urandom_range(3) != 0);
            bus.cr_resp[5*i +: 5] = r_resp[i];
          end else if (!mask[i]) begin
            bus.cr_valid[i]       = ($urandom_range(7) == 0);
            bus.cr_resp[5*i +: 5] = 5'($urandom);
          end else begin
            bus.cr_valid[i] = 1'b0;
          end
          if (mask[i] && r_resp[i][0] && cr_done[i] && cd_k[i] < BEATS) begin
            if (!(bus.cd_valid[i] && !hs_cd[i])) bus.cd_valid[i] = ($urandom_range(3) != 0);
            bus.cd_data[DATA_W*i +: DATA_W] = r_data[i][cd_k[i]];
            bus.cd_last[i] = (cd_k[i] == BEATS - 1) || (early && i == src && cd_k[i] == 1);
          end else begin
            bus.cd_valid[i] = 1'b0;
            bus.cd_last[i]  = 1'b0;
          end
        end
        bus.out_ready = toggle_rdy ? ~bus.out_ready : ($urandom_range(3) != 0);
      end
    end

    if (!fin) begin
      fail_now({tag, "_timeout"});
      do_reset();
      exp_beat_q.delete();
      exp_resp_q.delete();
    end else if (!aborted) begin
      drive_idle();
      check({tag, "_err"}, wide_t'(bus.err), wide_t'(exp_err));
      check({tag, "_beats_left"}, wide_t'(exp_beat_q.size()), '0);
      if (mask == '0) check({tag, "_latency"}, wide_t'(resp_cyc - start_cyc), wide_t'(2));
    end
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  initial begin
    drive_idle();
    do_reset();

    fill_data();
    for (int i = 0; i < N; i++) r_resp[i] = '0;
    r_resp[1] = 5'b00101;
    r_resp[2] = 5'b01001;
    run_round("t1", 8'h06, 1'b0, 1'b0, 1'b0);

    fill_data();
    for (int i = 0; i < N; i++) r_resp[i] = 5'b01000;
    run_round("t2", 8'h0F, 1'b0, 1'b0, 1'b0);

    fill_data();
    run_round("t3", 8'h00, 1'b0, 1'b0, 1'b0);

    fill_data();
    r_resp[0] = 5'b00001;
    r_resp[7] = 5'b00001;
    run_round("t4", 8'h81, 1'b0, 1'b0, 1'b1);

    fill_data();
    r_resp[2] = 5'b00101;
    r_resp[5] = 5'b00001;
    run_round("t5", 8'h24, 1'b1, 1'b0, 1'b0);

    fill_data();
    r_resp[0] = 5'b00001;
    r_resp[1] = 5'b00001;
    run_round("t6", 8'h03, 1'b0, 1'b1, 1'b0);

    fill_data();
    r_resp[3] = 5'b10001;
    run_round("t6_after", 8'h08, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      fill_data();
      run_round("rnd", N'($urandom), 1'b0, 1'b0, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
